ahb2mem: RTL and testbench
==========================

Name: ahb2mem

Overview:
- AHB-Lite slave bridge; converts single AHB transfers into mem-interface requests (mem_req_t) and returns mem responses (mem_resp_t) as AHB data-phase responses.
- Sits between the system AHB fabric and mem-interface slaves such as on-chip SRAM or peripheral adapters. It is the slave-side counterpart of the mem-to-AHB master bridge.
- Issues one mem request per AHB beat (req_burst=1). Multi-beat AHB bursts are handled as back-to-back singles.

Parameters:
- N_AW, 32, AHB/mem address width.
- N_DW, 32, AHB/mem data width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- hsel  in  1  slave select
- htrans  in  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
- hburst  in  3  burst type; ignored
- haddr  in  N_AW  address
- hsize  in  3  transfer size
- hwrite  in  1  1=write
- hwdata  in  N_DW  write data (data phase)
- hmastlock  in  1  ignored
- hprot  in  7  ignored
- hready  in  1  bus-level ready
- hreadyout  out  1  slave ready
- hresp  out  1  0=OKAY, 1=ERROR
- hrdata  out  N_DW  read data
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_req  out  mem_req_t  {req_type, req_mask, req_data, req_burst, req_addr}
- mem_resp_valid  in  1  response valid
- mem_resp_ready  out  1  response accept
- mem_resp  in  mem_resp_t  {resp_type, resp_data, resp_last}

Behaviour:
- Reset values: state IDLE, hreadyout=1, hresp=0, hrdata=0, mem_req_valid=0, mem_resp_ready=1, captured address/type/mask = 0.
- Address-phase sample: acc = hsel & hready & htrans[1]. On acc, register haddr, hwrite and mask; also register an error flag.
- Mask by hsize/haddr[1:0]:
  - BYTE: 4'b0001<<haddr[1:0]
  - HALF: haddr[1] ? 4'b1100 : 4'b0011
  - WORD: 4'b1111
- Error flag is set when: hsize>WORD, HALF with haddr[0]=1, or WORD with haddr[1:0]!=0.
- States (3-bit enum):
  - IDLE: hreadyout=1, hresp=0. acc & ~err -> REQ; acc & err -> ERR1; else stay.
  - REQ: hreadyout=0; mem_req_valid=1.
    - mem_req: req_type = MEM_WRITE/MEM_READ from registered hwrite; req_addr = registered haddr; req_mask = registered mask; req_data = hwdata (stable while hreadyout=0); req_burst = 1.
    - mem_req_ready -> RESP.
  - RESP: hreadyout=0, mem_resp_ready=1. mem_resp_valid -> register resp_data into hrdata (reads only; writes leave hrdata unchanged) -> DONE.
  - DONE: hreadyout=1, hresp=0; data phase completes. Same pipelining rules as IDLE: acc -> REQ/ERR1, else IDLE.
  - ERR1: hresp=1, hreadyout=0 -> ERR2.
  - ERR2: hresp=1, hreadyout=1. acc -> REQ/ERR1 (new address phase accepted), else IDLE.
- No mem request is issued for an errored transfer.
- Latency: zero-wait memory (ready and resp in the cycle offered) gives a 3-cycle data phase (2 wait states). Each extra cycle of mem_req_ready=0 or mem_resp_valid=0 adds one wait state.
- hrdata holds its last value except on a read capture.
- IDLE/BUSY htrans, or hsel=0: no state change; zero-wait OKAY.
- htrans/haddr sampled while hready=0: ignored.
- resp_type and resp_last are not checked. Responses arriving in IDLE/DONE/ERR* are accepted (mem_resp_ready=1) and discarded.
- mem_req_valid must not drop before mem_req_ready. mem_req fields stay stable while valid.
- rst mid-transfer: next cycle returns to IDLE with reset values. Any outstanding mem request is abandoned and a late response is discarded.
- Reset has priority over all transitions.

Test Plan:
- Word read: NONSEQ haddr=0x100, hsize=WORD, hwrite=0; memory zero-wait returning 0xDEADBEEF -> mem_req {READ, mask 4'hF, addr 0x100, burst 1}; hreadyout low 2 cycles, then high with hrdata=0xDEADBEEF, hresp=0.
- Byte write: haddr=0x1003, hsize=BYTE, hwdata=0xAB000000 -> mem_req {WRITE, mask 4'b1000, data 0xAB000000, addr 0x1003}; OKAY after response.
- Backpressure: mem_req_ready low 3 cycles, mem_resp_valid delayed 2 cycles -> 5 extra wait states; request fields stable throughout.
- Pipelined: NONSEQ read 0x0 then SEQ write 0x4 presented in the DONE cycle -> second request issued immediately after DONE, with no IDLE cycle in between.
- Error: WORD at haddr=0x102 -> no mem_req_valid; two-cycle ERROR (hresp=1 with hreadyout 0 then 1). HALF at 0x103 and hsize=DWORD also return ERROR.
- Reset mid-RESP: assert rst while waiting for response -> next cycle IDLE, hreadyout=1, mem_req_valid=0; late mem_resp_valid consumed with no AHB effect; subsequent read completes normally.

Source files
------------

// File: rtl/ahb2mem.sv
// rtl/ahb2mem.sv - AHB-Lite slave to mem-interface bridge, one mem request per AHB beat
package ahb2mem_pkg;
  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;

  typedef enum logic {MEM_READ = 1'b0, MEM_WRITE = 1'b1} mem_type_e;

  typedef struct packed {
    mem_type_e          req_type;
    logic [3:0]         req_mask;
    logic [MEM_DW-1:0]  req_data;
    logic [7:0]         req_burst;
    logic [MEM_AW-1:0]  req_addr;
  } mem_req_t;

  typedef struct packed {
    mem_type_e          resp_type;
    logic [MEM_DW-1:0]  resp_data;
    logic               resp_last;
  } mem_resp_t;
endpackage

module ahb2mem
  import ahb2mem_pkg::*;
#(
  parameter int N_AW = 32,
  parameter int N_DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hsel,
  input  logic [1:0]      htrans,
  input  logic [2:0]      hburst,
  input  logic [N_AW-1:0] haddr,
  input  logic [2:0]      hsize,
  input  logic            hwrite,
  input  logic [N_DW-1:0] hwdata,
  input  logic            hmastlock,
  input  logic [6:0]      hprot,
  input  logic            hready,
  output logic            hreadyout,
  output logic            hresp,
  output logic [N_DW-1:0] hrdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output mem_req_t        mem_req,
  input  logic            mem_resp_valid,
  output logic            mem_resp_ready,
  input  mem_resp_t       mem_resp
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DONE, S_ERR1, S_ERR2} state_e;

  state_e          state;
  logic [N_AW-1:0] addr_q;
  logic            write_q;
  logic [3:0]      mask_q;
  logic            acc;
  logic            err;
  logic [3:0]      mask;
  logic            unused_inputs;

  always_comb begin
    acc  = hsel & hready & htrans[1];
    mask = 4'b1111;
    case (hsize)
      3'd0:    mask = 4'b0001 << haddr[1:0];
      3'd1:    mask = haddr[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    err = (hsize > 3'd2) |
          ((hsize == 3'd1) & haddr[0]) |
          ((hsize == 3'd2) & (haddr[1:0] != 2'b00));
  end

  // hwdata is already valid in REQ because the data phase is held open by hreadyout=0
  always_comb begin
    mem_req           = '0;
    mem_req.req_type  = write_q ? MEM_WRITE : MEM_READ;
    mem_req.req_mask  = mask_q;
    mem_req.req_data  = hwdata;
    mem_req.req_burst = 8'd1;
    mem_req.req_addr  = addr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      hreadyout      <= 1'b1;
      hresp          <= 1'b0;
      hrdata         <= '0;
      mem_req_valid  <= 1'b0;
      mem_resp_ready <= 1'b1;
      addr_q         <= '0;
      write_q        <= 1'b0;
      mask_q         <= '0;
    end else begin
      mem_resp_ready <= 1'b1;
      case (state)
        // every state that ends with hreadyout=1 accepts the next address phase
        S_IDLE, S_DONE, S_ERR2: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= 1'b0;
          if (acc) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            mask_q  <= mask;
            hreadyout <= 1'b0;
            if (err) begin
              state <= S_ERR1;
              hresp <= 1'b1;
            end else begin
              state         <= S_REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            if (!write_q) hrdata <= mem_resp.resp_data;
            hreadyout <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_ERR1: begin
          hreadyout <= 1'b1;
          state     <= S_ERR2;
        end
        default: begin
          state         <= S_IDLE;
          hreadyout     <= 1'b1;
          hresp         <= 1'b0;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

  assign unused_inputs = ^{hburst, hmastlock, hprot, htrans[0],
                           mem_resp.resp_type, mem_resp.resp_last};

endmodule

// File: tb/tb_ahb2mem.sv
// tb/tb_ahb2mem.sv - directed self-checking bench for ahb2mem
module tb_ahb2mem;
  import ahb2mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hmastlock;
  logic [6:0]  hprot;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  mem_req_t    mem_req;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  mem_resp_t   mem_resp;

  int checks = 0;
  int errors = 0;
  int waits;

  always #5 clk = ~clk;
  assign hready = hreadyout;

  ahb2mem #(.N_AW(32), .N_DW(32)) dut (
    .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hburst(hburst),
    .haddr(haddr), .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata),
    .hmastlock(hmastlock), .hprot(hprot), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req(mem_req),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp(mem_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic [1:0] tr, input logic [31:0] a,
                            input logic [2:0] sz, input logic wr);
    hsel = 1'b1; htrans = tr; haddr = a; hsize = sz; hwrite = wr;
  endtask

  task automatic idle_bus();
    htrans = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hburst = 3'd0; haddr = '0;
    hsize = 3'd2; hwrite = 1'b0; hwdata = '0; hmastlock = 1'b0; hprot = '0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    mem_resp = '{resp_type: MEM_READ, resp_data: 32'h0, resp_last: 1'b1};

    // reset state
    tick(); tick();
    check("rst_hreadyout", hreadyout, 1);
    check("rst_hresp", hresp, 0);
    check("rst_hrdata", hrdata, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_resp_ready", mem_resp_ready, 1);
    check("rst_req_addr", mem_req.req_addr, 0);
    check("rst_req_mask", mem_req.req_mask, 0);
    rst = 1'b0;

    // BUSY and unselected transfers are ignored
    addr_phase(2'b01, 32'h100, 3'd2, 1'b0);
    tick();
    check("busy_hreadyout", hreadyout, 1);
    check("busy_req_valid", mem_req_valid, 0);
    addr_phase(2'b10, 32'h100, 3'd2, 1'b0);
    hsel = 1'b0;
    tick();
    check("unsel_hreadyout", hreadyout, 1);
    check("unsel_req_valid", mem_req_valid, 0);

    // word read, zero-wait memory
    mem_resp.resp_data = 32'hDEADBEEF;
    addr_phase(2'b10, 32'h100, 3'd2, 1'b0);
    tick(); idle_bus();
    check("rd_req_valid", mem_req_valid, 1);
    check("rd_hreadyout_w1", hreadyout, 0);
    check("rd_req_type", mem_req.req_type, MEM_READ);
    check("rd_req_mask", mem_req.req_mask, 4'hF);
    check("rd_req_addr", mem_req.req_addr, 32'h100);
    check("rd_req_burst", mem_req.req_burst, 1);
    tick();
    check("rd_hreadyout_w2", hreadyout, 0);
    check("rd_req_dropped", mem_req_valid, 0);
    tick();
    check("rd_done_hreadyout", hreadyout, 1);
    check("rd_done_hrdata", hrdata, 32'hDEADBEEF);
    check("rd_done_hresp", hresp, 0);
    tick();

    // byte write at lane 3
    addr_phase(2'b10, 32'h1003, 3'd0, 1'b1);
    tick(); idle_bus();
    hwdata = 32'hAB000000;
    #1;
    check("wr_req_valid", mem_req_valid, 1);
    check("wr_req_type", mem_req.req_type, MEM_WRITE);
    check("wr_req_mask", mem_req.req_mask, 4'b1000);
    check("wr_req_data", mem_req.req_data, 32'hAB000000);
    check("wr_req_addr", mem_req.req_addr, 32'h1003);
    tick(); tick();
    check("wr_done_hreadyout", hreadyout, 1);
    check("wr_done_hresp", hresp, 0);
    check("wr_hrdata_held", hrdata, 32'hDEADBEEF);
    hwdata = '0;
    tick();

    // upper halfword read
    mem_resp.resp_data = 32'h11223344;
    addr_phase(2'b10, 32'h2, 3'd1, 1'b0);
    tick(); idle_bus();
    check("half_req_mask", mem_req.req_mask, 4'b1100);
    tick(); tick();
    check("half_hrdata", hrdata, 32'h11223344);
    tick();

    // backpressure: req_ready low 3 cycles, resp_valid late 2 cycles
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    waits = 0;
    addr_phase(2'b10, 32'h200, 3'd2, 1'b0);
    tick(); idle_bus();
    for (int i = 1; i <= 4; i++) begin
      if (!hreadyout) waits++;
      check("bp_req_valid", mem_req_valid, 1);
      check("bp_req_addr", mem_req.req_addr, 32'h200);
      check("bp_req_mask", mem_req.req_mask, 4'hF);
      if (i == 4) mem_req_ready = 1'b1;
      tick();
    end
    mem_req_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      if (!hreadyout) waits++;
      check("bp_resp_wait_valid", mem_req_valid, 0);
      if (j == 3) begin
        mem_resp_valid = 1'b1;
        mem_resp.resp_data = 32'h12345678;
      end
      tick();
    end
    check("bp_done_hreadyout", hreadyout, 1);
    check("bp_done_hrdata", hrdata, 32'h12345678);
    check("bp_wait_states", waits, 7);
    mem_req_ready = 1'b1;
    tick();

    // pipelined: read 0x0 then SEQ write 0x4 presented in the DONE cycle
    mem_resp.resp_data = 32'h0BADF00D;
    addr_phase(2'b10, 32'h0, 3'd2, 1'b0);
    tick(); idle_bus();
    tick(); tick();
    check("pipe_done_hreadyout", hreadyout, 1);
    check("pipe_done_hrdata", hrdata, 32'h0BADF00D);
    addr_phase(2'b11, 32'h4, 3'd2, 1'b1);
    tick(); idle_bus();
    check("pipe_req2_hreadyout", hreadyout, 0);
    check("pipe_req2_valid", mem_req_valid, 1);
    check("pipe_req2_type", mem_req.req_type, MEM_WRITE);
    check("pipe_req2_addr", mem_req.req_addr, 32'h4);
    hwdata = 32'hCAFEF00D;
    #1;
    check("pipe_req2_data", mem_req.req_data, 32'hCAFEF00D);
    tick(); tick();
    check("pipe_done2_hreadyout", hreadyout, 1);
    check("pipe_done2_hrdata", hrdata, 32'h0BADF00D);
    hwdata = '0;
    tick();

    // misaligned word
    addr_phase(2'b10, 32'h102, 3'd2, 1'b0);
    tick(); idle_bus();
    check("errw_e1_hresp", hresp, 1);
    check("errw_e1_hreadyout", hreadyout, 0);
    check("errw_e1_valid", mem_req_valid, 0);
    tick();
    check("errw_e2_hresp", hresp, 1);
    check("errw_e2_hreadyout", hreadyout, 1);
    check("errw_e2_valid", mem_req_valid, 0);
    tick();
    check("errw_idle_hresp", hresp, 0);

    // misaligned half, then DWORD accepted out of ERR2
    addr_phase(2'b10, 32'h103, 3'd1, 1'b0);
    tick();
    check("errh_e1_hresp", hresp, 1);
    check("errh_e1_hreadyout", hreadyout, 0);
    addr_phase(2'b10, 32'h108, 3'd3, 1'b0);
    tick();
    check("errh_e2_hresp", hresp, 1);
    check("errh_e2_hreadyout", hreadyout, 1);
    tick(); idle_bus();
    check("errd_e1_hresp", hresp, 1);
    check("errd_e1_hreadyout", hreadyout, 0);
    check("errd_e1_valid", mem_req_valid, 0);
    tick(); tick();
    check("errd_idle_hresp", hresp, 0);
    check("errd_idle_hreadyout", hreadyout, 1);

    // reset while waiting for the response
    mem_resp_valid = 1'b0;
    mem_resp.resp_data = 32'hFFFFFFFF;
    addr_phase(2'b10, 32'h300, 3'd2, 1'b0);
    tick(); idle_bus();
    tick();
    check("rr_resp_hreadyout", hreadyout, 0);
    rst = 1'b1;
    tick();
    check("rr_hreadyout", hreadyout, 1);
    check("rr_req_valid", mem_req_valid, 0);
    check("rr_hrdata", hrdata, 0);
    check("rr_req_addr", mem_req.req_addr, 0);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    tick();
    check("rr_late_hrdata", hrdata, 0);
    check("rr_late_hreadyout", hreadyout, 1);
    mem_resp.resp_data = 32'h55AA55AA;
    addr_phase(2'b10, 32'h304, 3'd2, 1'b0);
    tick(); idle_bus();
    check("rr_next_addr", mem_req.req_addr, 32'h304);
    tick(); tick();
    check("rr_next_hreadyout", hreadyout, 1);
    check("rr_next_hrdata", hrdata, 32'h55AA55AA);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
